// File: rtl/ber_lat_checker.sv
// Receive-path BER checker: phase pick, bit slice, PRBS latency search and
// lock supervision with saturating error/bit totals.
module ber_lat_checker #(
  parameter int unsigned NB_INPUT = 8,
  parameter int unsigned N_PHASES = 4,
  parameter int unsigned NB_SEL   = 2,
  parameter int unsigned MAX_LAT  = 511,
  parameter int unsigned NB_LAT   = 9,
  parameter int unsigned WINDOW   = 511,
  parameter int unsigned NB_WIN   = 9,
  parameter int unsigned ERR_THR  = 100,
  parameter int unsigned NB_ACC   = 32
) (
  input  logic                       clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_sym_valid,
  input  logic                       i_prbs_bit,
  input  logic [NB_SEL-1:0]          i_phase_sel,
  input  logic signed [NB_INPUT-1:0] i_sample,
  input  logic                       i_clear,
  output logic                       o_locked,
  output logic [NB_LAT-1:0]          o_lat_pos,
  output logic [NB_WIN-1:0]          o_win_errors,
  output logic [NB_ACC-1:0]          o_err_total,
  output logic [NB_ACC-1:0]          o_bit_total,
  output logic                       o_ber_zero
);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t                      state, state_nxt;
  logic signed [NB_INPUT-1:0]  phase_buf [N_PHASES];
  logic                        r_dec;
  logic [MAX_LAT:0]            r_ref;
  logic [NB_WIN-1:0]           win_cnt, win_err, win_tot;
  logic [NB_LAT-1:0]           lat_pos, lat_nxt;
  logic                        strobe, err, win_end, dec_c;

  assign strobe  = i_enable & i_sym_valid;
  assign err     = r_dec ^ r_ref[lat_pos];
  assign win_tot = win_err + NB_WIN'(err);
  assign win_end = (win_cnt == NB_WIN'(WINDOW - 1));
  // Strictly positive: sign bit clear and not zero.
  assign dec_c   = ~phase_buf[i_phase_sel][NB_INPUT-1] && (phase_buf[i_phase_sel] != '0);

  // Oversampled phase buffer, shifts at the sample rate
  always_ff @(posedge clock) begin
    if (i_reset) begin
      for (int k = 0; k < int'(N_PHASES); k++) phase_buf[k] <= '0;
    end else if (i_enable) begin
      phase_buf[0] <= i_sample;
      for (int k = 1; k < int'(N_PHASES); k++) phase_buf[k] <= phase_buf[k-1];
    end
  end

  // Decision and reference delay line
  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_dec <= 1'b0;
      r_ref <= '0;
    end else if (strobe) begin
      r_dec <= dec_c;
      r_ref <= {r_ref[MAX_LAT-1:0], i_prbs_bit};
    end
  end

  // Window counters
  always_ff @(posedge clock) begin
    if (i_reset) begin
      win_cnt      <= '0;
      win_err      <= '0;
      o_win_errors <= '0;
    end else if (strobe) begin
      if (win_end) begin
        win_cnt      <= '0;
        win_err      <= '0;
        o_win_errors <= win_tot;
      end else begin
        win_cnt <= win_cnt + NB_WIN'(1);
        win_err <= win_tot;
      end
    end
  end

  // Lock FSM state register
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state    <= SEARCH;
      o_locked <= 1'b0;
      lat_pos  <= '0;
    end else begin
      state    <= state_nxt;
      o_locked <= (state_nxt == LOCKED);
      lat_pos  <= lat_nxt;
    end
  end

  // Next state: a rejected window advances the latency, a failed lock keeps it
  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_pos;
    if (strobe && win_end) begin
      case (state)
        SEARCH: begin
          if (win_tot <= NB_WIN'(ERR_THR)) state_nxt = LOCKED;
          else lat_nxt = (lat_pos == NB_LAT'(MAX_LAT)) ? '0 : lat_pos + NB_LAT'(1);
        end
        LOCKED: begin
          if (win_tot > NB_WIN'(ERR_THR)) state_nxt = SEARCH;
        end
        default: state_nxt = SEARCH;
      endcase
    end
  end

  // Saturating totals; a clear keeps only the current strobe's contribution
  always_ff @(posedge clock) begin
    if (i_reset) begin
      o_err_total <= '0;
      o_bit_total <= '0;
    end else if (i_clear) begin
      o_bit_total <= (strobe && state == LOCKED) ? NB_ACC'(1) : '0;
      o_err_total <= (strobe && state == LOCKED) ? NB_ACC'(err) : '0;
    end else if (strobe && state == LOCKED) begin
      if (~&o_bit_total)        o_bit_total <= o_bit_total + NB_ACC'(1);
      if (err && ~&o_err_total) o_err_total <= o_err_total + NB_ACC'(1);
    end
  end

  assign o_lat_pos  = lat_pos;
  assign o_ber_zero = o_locked & (o_win_errors == '0);

endmodule

// File: tb/tb_ber_lat_checker.sv
// Scoreboard bench for ber_lat_checker at reduced size (8 latencies, 16-symbol windows).
module tb_ber_lat_checker;
  localparam int NB_INPUT = 8;
  localparam int N_PHASES = 4;
  localparam int NB_SEL   = 2;
  localparam int MAX_LAT  = 7;
  localparam int NB_LAT   = 3;
  localparam int WINDOW   = 16;
  localparam int NB_WIN   = 5;
  localparam int ERR_THR  = 2;
  localparam int NB_ACC   = 4;
  localparam int ACC_MAX  = 15;

  logic                       clock;
  logic                       i_reset, i_enable, i_sym_valid, i_prbs_bit, i_clear;
  logic [NB_SEL-1:0]          i_phase_sel;
  logic signed [NB_INPUT-1:0] i_sample;
  logic                       o_locked, o_ber_zero;
  logic [NB_LAT-1:0]          o_lat_pos;
  logic [NB_WIN-1:0]          o_win_errors;
  logic [NB_ACC-1:0]          o_err_total, o_bit_total;

  ber_lat_checker #(
    .NB_INPUT(NB_INPUT), .N_PHASES(N_PHASES), .NB_SEL(NB_SEL), .MAX_LAT(MAX_LAT),
    .NB_LAT(NB_LAT), .WINDOW(WINDOW), .NB_WIN(NB_WIN), .ERR_THR(ERR_THR), .NB_ACC(NB_ACC)
  ) dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_sym_valid(i_sym_valid),
    .i_prbs_bit(i_prbs_bit), .i_phase_sel(i_phase_sel), .i_sample(i_sample),
    .i_clear(i_clear), .o_locked(o_locked), .o_lat_pos(o_lat_pos),
    .o_win_errors(o_win_errors), .o_err_total(o_err_total), .o_bit_total(o_bit_total),
    .o_ber_zero(o_ber_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit locked;
    int lat;
    int win_errors;
    int err_tot;
    int bit_tot;
    bit ber_zero;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model, kept as per-strobe histories since reset
  bit   m_locked;
  int   m_lat, m_wcnt, m_werr, m_wlast, m_etot, m_btot;
  int   samp_q[$];
  bit   prbs_h[$];
  bit   dec_h[$];
  bit   prbs_seq[256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int sat(input int x);
    return (x > ACC_MAX) ? ACC_MAX : x;
  endfunction

  task automatic model_edge();
    bit strobe, err, rbit, d, prev_dec, was_locked;
    int n, idx, tot, v, sel;
    if (i_reset) begin
      m_locked = 0; m_lat = 0; m_wcnt = 0; m_werr = 0; m_wlast = 0; m_etot = 0; m_btot = 0;
      samp_q.delete(); prbs_h.delete(); dec_h.delete();
      return;
    end
    strobe     = i_enable && i_sym_valid;
    was_locked = m_locked;
    if (i_clear) begin
      m_etot = 0;
      m_btot = 0;
    end
    if (strobe) begin
      n        = prbs_h.size();
      idx      = n - 1 - m_lat;
      rbit     = (idx >= 0) ? prbs_h[idx] : 1'b0;
      prev_dec = (dec_h.size() > 0) ? dec_h[dec_h.size() - 1] : 1'b0;
      err      = prev_dec ^ rbit;
      sel      = int'(i_phase_sel);
      v        = (samp_q.size() > sel) ? samp_q[samp_q.size() - 1 - sel] : 0;
      d        = (v > 0);
      if (was_locked) begin
        m_btot = sat(m_btot + 1);
        m_etot = sat(m_etot + int'(err));
      end
      tot = m_werr + int'(err);
      if (m_wcnt == WINDOW - 1) begin
        m_wlast = tot;
        m_wcnt  = 0;
        m_werr  = 0;
        if (was_locked) m_locked = (tot <= ERR_THR);
        else if (tot <= ERR_THR) m_locked = 1;
        else m_lat = (m_lat + 1) % (MAX_LAT + 1);
      end else begin
        m_wcnt++;
        m_werr = tot;
      end
      prbs_h.push_back(i_prbs_bit);
      dec_h.push_back(d);
    end
    if (i_enable) begin
      samp_q.push_back(int'(i_sample));
      if (samp_q.size() > N_PHASES) void'(samp_q.pop_front());
    end
  endtask

  // One clock with the currently driven inputs; expectation queued at the edge, checked 1ns later
  task automatic cycle();
    exp_t e;
    @(posedge clock);
    model_edge();
    e.locked     = m_locked;
    e.lat        = m_lat;
    e.win_errors = m_wlast;
    e.err_tot    = m_etot;
    e.bit_tot    = m_btot;
    e.ber_zero   = m_locked && (m_wlast == 0);
    sb_q.push_back(e);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard: observed empty queue expected entry");
    end else begin
      e = sb_q.pop_front();
      chk("locked", 32'(o_locked), 32'(e.locked));
      chk("lat_pos", 32'(o_lat_pos), e.lat);
      chk("win_errors", 32'(o_win_errors), e.win_errors);
      chk("err_total", 32'(o_err_total), e.err_tot);
      chk("bit_total", 32'(o_bit_total), e.bit_tot);
      chk("ber_zero", 32'(o_ber_zero), 32'(e.ber_zero));
    end
  endtask

  // One symbol: 4 enabled sample cycles, strobe on the last one
  task automatic send_sym(input bit sbit, input bit pbit, input bit clr);
    for (int c = 0; c < 4; c++) begin
      i_enable    = 1'b1;
      i_sym_valid = (c == 3);
      i_prbs_bit  = pbit;
      i_sample    = sbit ? 8'sd64 : -8'sd64;
      i_clear     = clr && (c == 3);
      cycle();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"}, 32'(o_locked), 0);
    chk({tag, "_lat"}, 32'(o_lat_pos), 0);
    chk({tag, "_win"}, 32'(o_win_errors), 0);
    chk({tag, "_err"}, 32'(o_err_total), 0);
    chk({tag, "_bit"}, 32'(o_bit_total), 0);
    chk({tag, "_berz"}, 32'(o_ber_zero), 0);
  endtask

  initial begin
    logic [8:0] lfsr;
    bit flip, sbit;
    lfsr = 9'h1FF;
    for (int i = 0; i < 256; i++) begin
      prbs_seq[i] = lfsr[8];
      lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    end

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      i_reset     = 1'b1;
      i_enable    = 1'($urandom);
      i_sym_valid = 1'($urandom);
      i_prbs_bit  = 1'($urandom);
      i_clear     = 1'($urandom);
      i_phase_sel = 2'($urandom);
      i_sample    = 8'($urandom);
      cycle();
    end
    chk_all_zero("reset");

    // Enable held low: nothing may move
    i_reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      i_enable    = 1'b0;
      i_sym_valid = 1'($urandom);
      i_prbs_bit  = 1'($urandom);
      i_clear     = 1'($urandom);
      i_phase_sel = 2'($urandom);
      i_sample    = 8'($urandom);
      cycle();
    end
    chk_all_zero("idle");

    // PRBS stream with the slicer seeing the bit 5 strobes behind the reference
    i_phase_sel = 2'd3;
    for (int s = 0; s < 183; s++) begin
      flip = (s == 118) || (s == 128) || (s == 130) || (s == 144) || (s == 146) ||
             (s == 148) || (s == 160) || (s == 162);
      sbit = ((s >= 4) ? prbs_seq[s-4] : 1'b0) ^ flip;
      send_sym(sbit, prbs_seq[s], s == 120);
      case (s)
        94: chk("pre_lock", 32'(o_locked), 0);
        95: begin
          chk("lock_locked", 32'(o_locked), 1);
          chk("lock_lat", 32'(o_lat_pos), 5);
          chk("lock_berz", 32'(o_ber_zero), 1);
          chk("lock_err", 32'(o_err_total), 0);
        end
        115: begin
          chk("sat_bit", 32'(o_bit_total), 15);
          chk("sat_err", 32'(o_err_total), 0);
        end
        120: begin
          chk("clear_bit", 32'(o_bit_total), 1);
          chk("clear_err", 32'(o_err_total), 1);
        end
        143: begin
          chk("thr2_locked", 32'(o_locked), 1);
          chk("thr2_win", 32'(o_win_errors), 2);
        end
        158: chk("thr3_pre", 32'(o_locked), 1);
        159: begin
          chk("thr3_locked", 32'(o_locked), 0);
          chk("thr3_lat", 32'(o_lat_pos), 5);
          chk("thr3_win", 32'(o_win_errors), 3);
        end
        175: begin
          chk("relock_locked", 32'(o_locked), 1);
          chk("relock_lat", 32'(o_lat_pos), 5);
        end
        default: ;
      endcase
    end

    // Reset mid-window while locked, with a strobe present
    i_reset     = 1'b1;
    i_enable    = 1'b1;
    i_sym_valid = 1'b1;
    cycle();
    i_reset = 1'b0;
    chk_all_zero("midrst");

    // Uncorrelated stream: every window rejected, latency wraps
    for (int s = 0; s < 160; s++) begin
      if (s % 5 == 0) begin
        i_enable    = 1'b0;
        i_sym_valid = 1'b1;
        i_clear     = 1'b0;
        cycle();
      end
      send_sym(1'b0, 1'b1, 1'b0);
      if (s % WINDOW == WINDOW - 1) begin
        chk("wrap_lat", 32'(o_lat_pos), ((s / WINDOW) + 1) % (MAX_LAT + 1));
        chk("wrap_locked", 32'(o_locked), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
